serial_echo_buffer: RTL

SERIAL_ECHO_BUFFER -- requirements
Module: serial_echo_buffer

---
 rtl/serial_echo_buffer_pkg.sv | 52 +++++
 rtl/serial_echo_buffer_sync_fifo.sv | 65 ++++++
 rtl/serial_echo_buffer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_echo_buffer_pkg.sv
// Shared definitions for the serial echo buffer: FSM encodings, bit-period
// derivation, parameter legality and small byte helpers.
package serial_echo_buffer_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_e;

  localparam int MIN_CPB = 4;

  function automatic int calc_cpb(input int clk_hz, input int baud);
    return (baud > 0) ? clk_hz / baud : 0;
  endfunction

  function automatic bit is_pow2(input int v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

  function automatic bit params_legal(input int clk_hz, input int baud,
                                      input int depth, input int stop_bits,
                                      input int case_swap, input int led_mode);
    return (calc_cpb(clk_hz, baud) >= MIN_CPB) && is_pow2(depth) &&
           (stop_bits == 1 || stop_bits == 2) &&
           (case_swap == 0 || case_swap == 1) &&
           (led_mode == 0 || led_mode == 1);
  endfunction

  function automatic logic [7:0] swap_case(input logic [7:0] b);
    logic [7:0] r;
    r = b;
    if (b >= 8'h41 && b <= 8'h5A) r = b + 8'h20;
    else if (b >= 8'h61 && b <= 8'h7A) r = b - 8'h20;
    return r;
  endfunction

  // LED status field only has six bits for occupancy
  function automatic logic [5:0] sat_occupancy(input int count);
    if (count >= 63) return 6'd63;
    return 6'(count);
  endfunction

endpackage

// File: rtl/serial_echo_buffer_sync_fifo.sv
// Synchronous FIFO with combinational read data (first word fall-through),
// exact 0..DEPTH occupancy and push-while-full accepted only alongside a pop.
module sync_fifo
  import serial_echo_buffer_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  generate
    if (!is_pow2(DEPTH) || WIDTH < 1) begin : g_param_check
      $error("sync_fifo: DEPTH must be a power of two >= 2 and WIDTH >= 1");
    end
  endgenerate

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wrPtr_q, rdPtr_q;
  logic [CW-1:0]    count_q;
  logic             wrEn_d, rdEn_d;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rdPtr_q];

  // A full FIFO still takes a write when the head leaves in the same cycle
  assign wrEn_d = push_i && (!full_o || pop_i);
  assign rdEn_d = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (wrEn_d) mem_q[wrPtr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (wrEn_d) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (rdEn_d) rdPtr_q <= rdPtr_q + PTR_ONE;
      case ({wrEn_d, rdEn_d})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/serial_echo_buffer.sv
// UART echo: 8N1 receiver feeding a FIFO that drains into a transmitter,
// with optional letter-case swap and a last-byte / status LED register.
module serial_echo_buffer
  import serial_echo_buffer_pkg::*;
#(
  parameter int CLK_HZ       = 100000000,
  parameter int BAUD         = 1000000,
  parameter int DEPTH        = 16,
  parameter int TX_STOP_BITS = 1,
  parameter int CASE_SWAP    = 0,
  parameter int LED_MODE     = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       usbRx,
  output logic       usbTx,
  output logic [7:0] led
);

  localparam int CPB      = calc_cpb(CLK_HZ, BAUD);
  localparam int STOP_CYC = CPB * TX_STOP_BITS;
  localparam int CNT_W    = $clog2(STOP_CYC + 1);
  localparam int CW       = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  generate
    if (!params_legal(CLK_HZ, BAUD, DEPTH, TX_STOP_BITS, CASE_SWAP, LED_MODE)) begin : g_param_check
      $error("serial_echo_buffer: illegal parameters (CPB >= 4, DEPTH pow2 >= 2, TX_STOP_BITS 1/2, CASE_SWAP/LED_MODE 0/1)");
    end
  endgenerate

  logic             sync1_q, sync2_q;
  rx_state_e        rxState_q;
  logic [CNT_W-1:0] rxCnt_q;
  logic [2:0]       rxBit_q;
  logic [7:0]       rxShift_q;
  logic             rxPush_q;
  logic             stopBad_q;
  logic             frameErr_q;
  logic             overflow_q;

  tx_state_e        txState_q;
  logic [CNT_W-1:0] txCnt_q;
  logic [2:0]       txBit_q;
  logic [7:0]       txShift_q;
  logic             usbTx_q;
  logic [7:0]       led_q;

  logic             fifoFull, fifoEmpty, fifoPop_d;
  logic [7:0]       fifoRdata, txByte_d;
  logic [CW-1:0]    fifoCount;

  assign usbTx = usbTx_q;
  assign led   = led_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= usbRx;
      sync2_q <= sync1_q;
    end
  end

  // Receiver: start is re-checked at mid-bit, then every CPB cycles after that
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxState_q  <= RX_IDLE;
      rxCnt_q    <= '0;
      rxBit_q    <= '0;
      rxShift_q  <= '0;
      rxPush_q   <= 1'b0;
      stopBad_q  <= 1'b0;
      frameErr_q <= 1'b0;
    end else begin
      rxPush_q <= 1'b0;
      case (rxState_q)
        RX_IDLE: begin
          if (!sync2_q) begin
            rxState_q <= RX_START;
            rxCnt_q   <= CNT_W'(CPB / 2);
          end
        end
        RX_START: begin
          if (rxCnt_q != '0) begin
            rxCnt_q <= rxCnt_q - CNT_ONE;
          end else if (!sync2_q) begin
            rxState_q <= RX_DATA;
            rxCnt_q   <= CNT_W'(CPB - 1);
            rxBit_q   <= '0;
          end else begin
            rxState_q <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (rxCnt_q != '0) begin
            rxCnt_q <= rxCnt_q - CNT_ONE;
          end else begin
            rxShift_q <= {sync2_q, rxShift_q[7:1]};
            rxCnt_q   <= CNT_W'(CPB - 1);
            if (rxBit_q == 3'd7) begin
              rxState_q <= RX_STOP;
              stopBad_q <= 1'b0;
            end else begin
              rxBit_q <= rxBit_q + 3'd1;
            end
          end
        end
        RX_STOP: begin
          // A bad stop parks here until the line idles so the tail is not re-framed
          if (rxCnt_q != '0) begin
            rxCnt_q <= rxCnt_q - CNT_ONE;
          end else if (sync2_q) begin
            rxState_q <= RX_IDLE;
            rxPush_q  <= !stopBad_q;
          end else if (!stopBad_q) begin
            stopBad_q  <= 1'b1;
            frameErr_q <= 1'b1;
          end
        end
        default: rxState_q <= RX_IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (rxPush_q),
    .pop_i   (fifoPop_d),
    .wdata_i (rxShift_q),
    .rdata_o (fifoRdata),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .count_o (fifoCount)
  );

  always_comb begin
    fifoPop_d = 1'b0;
    if (!fifoEmpty) begin
      if (txState_q == TX_IDLE) fifoPop_d = 1'b1;
      else if (txState_q == TX_STOP && txCnt_q == '0) fifoPop_d = 1'b1;
    end
  end

  assign txByte_d = (CASE_SWAP != 0) ? swap_case(fifoRdata) : fifoRdata;

  // Transmitter: popping from the last stop cycle gives gapless back-to-back frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      txState_q <= TX_IDLE;
      txCnt_q   <= '0;
      txBit_q   <= '0;
      txShift_q <= '0;
      usbTx_q   <= 1'b1;
    end else begin
      case (txState_q)
        TX_IDLE: begin
          if (fifoPop_d) begin
            txState_q <= TX_START;
            txShift_q <= txByte_d;
            txCnt_q   <= CNT_W'(CPB - 1);
            usbTx_q   <= 1'b0;
          end
        end
        TX_START: begin
          if (txCnt_q != '0) begin
            txCnt_q <= txCnt_q - CNT_ONE;
          end else begin
            txState_q <= TX_DATA;
            usbTx_q   <= txShift_q[0];
            txShift_q <= {1'b0, txShift_q[7:1]};
            txBit_q   <= '0;
            txCnt_q   <= CNT_W'(CPB - 1);
          end
        end
        TX_DATA: begin
          if (txCnt_q != '0) begin
            txCnt_q <= txCnt_q - CNT_ONE;
          end else if (txBit_q == 3'd7) begin
            txState_q <= TX_STOP;
            usbTx_q   <= 1'b1;
            txCnt_q   <= CNT_W'(STOP_CYC - 1);
          end else begin
            usbTx_q   <= txShift_q[0];
            txShift_q <= {1'b0, txShift_q[7:1]};
            txBit_q   <= txBit_q + 3'd1;
            txCnt_q   <= CNT_W'(CPB - 1);
          end
        end
        TX_STOP: begin
          if (txCnt_q != '0) begin
            txCnt_q <= txCnt_q - CNT_ONE;
          end else if (fifoPop_d) begin
            txState_q <= TX_START;
            txShift_q <= txByte_d;
            txCnt_q   <= CNT_W'(CPB - 1);
            usbTx_q   <= 1'b0;
          end else begin
            txState_q <= TX_IDLE;
          end
        end
        default: txState_q <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      led_q      <= '0;
    end else begin
      if (rxPush_q && fifoFull && !fifoPop_d) overflow_q <= 1'b1;
      if (LED_MODE == 0) begin
        if (rxPush_q) led_q <= rxShift_q;
      end else begin
        led_q <= {overflow_q, frameErr_q, sat_occupancy(int'(fifoCount))};
      end
    end
  end

endmodule
